// File: rtl/gf2m_pkg.sv
// Shared constants and FSM encoding for the GF(2^131) inverter datapath.
package gf2m_pkg;

  localparam int W = 136;
  localparam int M = 131;

  // x^131 + x^13 + x^2 + x + 1
  localparam logic [M:0] F_POLY = ((M+1)'(1) << M) | ((M+1)'(1) << 13) | (M+1)'(7);

  localparam int DEG_W = $clog2(M + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_U,
    SHIFT_V,
    COMBINE,
    DONE
  } state_t;

endpackage

// File: rtl/gf2m_div_x.sv
// Combinational g -> g/x mod F_POLY: halve directly when even, fold in F_POLY first when odd.
module gf2m_div_x
  import gf2m_pkg::*;
(
  input  logic [M:0] g,
  output logic [M:0] q
);

  assign q = g[0] ? ((g ^ F_POLY) >> 1) : (g >> 1);

endmodule

// File: rtl/gf2m_inverter.sv
// Sequential GF(2^M) inverter (binary extended Euclid) with valid/ready on both sides.
module gf2m_inverter
  import gf2m_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] inv,
  output logic         err
);

  state_t       state_q, state_d;
  logic [M:0]   u_q, u_d, v_q, v_d;
  logic [M:0]   g1_q, g1_d, g2_q, g2_d;
  logic [M:0]   g1_half, g2_half;
  logic [M-1:0] res_q, res_d;
  logic         err_q, err_d;
  logic         unused_a_hi;

  function automatic logic [DEG_W-1:0] deg(input logic [M:0] p);
    logic [DEG_W-1:0] d;
    d = '0;
    for (int i = 0; i <= M; i++) begin
      if (p[i]) d = DEG_W'(i);
    end
    return d;
  endfunction

  gf2m_div_x u_div_g1 (.g(g1_q), .q(g1_half));
  gf2m_div_x u_div_g2 (.g(g2_q), .q(g2_half));

  // Invariants: g1*a == u and g2*a == v (mod F_POLY); every step preserves both.
  always_comb begin
    // NOTE: every output of this block is given its hold value first so no path infers a latch.
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d  = {1'b0, a[M-1:0]};
          v_d  = F_POLY;
          g1_d = (M+1)'(1);
          g2_d = '0;
          if (a[M-1:0] == '0) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SHIFT_U;
          end
        end
      end

      // Next state looks at the bit that becomes the LSB, so no idle check cycle is spent.
      SHIFT_U: begin
        if (!u_q[0]) begin
          u_d     = u_q >> 1;
          g1_d    = g1_half;
          state_d = !u_q[1] ? SHIFT_U : (v_q[0] ? COMBINE : SHIFT_V);
        end else if (!v_q[0]) begin
          v_d     = v_q >> 1;
          g2_d    = g2_half;
          state_d = v_q[1] ? COMBINE : SHIFT_V;
        end else begin
          state_d = COMBINE;
        end
      end

      SHIFT_V: begin
        if (!v_q[0]) begin
          v_d     = v_q >> 1;
          g2_d    = g2_half;
          state_d = v_q[1] ? COMBINE : SHIFT_V;
        end else begin
          state_d = COMBINE;
        end
      end

      COMBINE: begin
        if (u_q == (M+1)'(1) || v_q == (M+1)'(1)) begin
          res_d   = (u_q == (M+1)'(1)) ? g1_q[M-1:0] : g2_q[M-1:0];
          state_d = DONE;
        end else if (deg(u_q) > deg(v_q)) begin
          u_d     = u_q ^ v_q;
          g1_d    = g1_q ^ g2_q;
          state_d = SHIFT_U;
        end else begin
          v_d     = v_q ^ u_q;
          g2_d    = g2_q ^ g1_q;
          state_d = SHIFT_U;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign inv         = {{(W-M){1'b0}}, res_q};
  assign err         = err_q;
  assign unused_a_hi = ^a[W-1:M];

endmodule

// File: tb/tb_gf2m_inverter.sv
// Scoreboard bench for gf2m_inverter: results are verified with a shift-and-add field multiply.
module tb_gf2m_inverter;
  import gf2m_pkg::*;

  localparam int LAT_MAX  = 4*M + 4;
  localparam int N_RANDOM = 100;

  typedef struct {
    logic [M-1:0] op;
    bit           exact;
    logic [W-1:0] inv;
    logic         err;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] inv;
  logic         err;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_sent = 0;
  int           n_results = 0;
  bit           holding = 0;
  bit           bp_mode = 0;
  int           hs_cyc = 0;

  gf2m_inverter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .inv      (inv),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input bit ok, input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference product: schoolbook shift-and-add, reducing by F_POLY whenever x^M appears.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M:0] acc;
    logic [M:0] xs;
    acc = '0;
    xs  = {1'b0, x};
    for (int i = 0; i < M; i++) begin
      if (y[i]) acc = acc ^ xs;
      xs = xs << 1;
      if (xs[M]) xs = xs ^ F_POLY;
    end
    return acc[M-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Random operand, often of reduced degree, always with junk above bit M-1.
  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    int           d;
    r = rand_w();
    if ($urandom_range(1) == 1) begin
      d = $urandom_range(M - 1, 1);
      r[M-1:0] = r[M-1:0] & ((M'(1) << d) - M'(1));
    end
    if (r[M-1:0] == '0) r[0] = 1'b1;
    return r;
  endfunction

  task automatic send(input logic [W-1:0] op, input bit exact, input logic [W-1:0] want_inv,
                      input logic want_err, input int want_lat, output int acc);
    exp_t e;
    int   guard = 0;
    int   c;
    acc = -1;
    @(negedge clk);
    a        = op;
    in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", W'(guard), W'(2000));
      in_valid = 1'b0;
      return;
    end
    c = cyc;
    @(posedge clk);
    e.op      = op[M-1:0];
    e.exact   = exact;
    e.inv     = want_inv;
    e.err     = want_err;
    e.lat     = want_lat;
    e.acc_cyc = c + 1;
    sb.push_back(e);
    n_sent++;
    acc = c + 1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = rand_w();
  endtask

  task automatic send_rand();
    int acc;
    send(rand_op(), 1'b0, '0, 1'b0, -1, acc);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || holding) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check(sb.size() == 0 && !holding, "drain_timeout", W'(sb.size()), '0);
    @(negedge clk);
  endtask

  task automatic check_result();
    exp_t         e;
    int           lat;
    logic [M-1:0] prod;
    check(sb.size() != 0, "unexpected_out_valid", W'(out_valid), '0);
    if (sb.size() == 0) return;
    e   = sb.pop_front();
    n_results++;
    lat = cyc - e.acc_cyc;
    check(lat <= LAT_MAX, "latency_max", W'(lat), W'(LAT_MAX));
    if (e.lat >= 0) check(lat == e.lat, "latency", W'(lat), W'(e.lat));
    if (e.exact) begin
      check(inv == e.inv, "inv_exact", inv, e.inv);
      check(err == e.err, "err_exact", W'(err), W'(e.err));
    end else begin
      check(err == 1'b0, "err_random", W'(err), '0);
      check(inv[W-1:M] == '0, "inv_high_bits", inv, '0);
      prod = gf_mul(e.op, inv[M-1:0]);
      check(prod == M'(1), "a_times_inv", W'(prod), W'(1));
    end
  endtask

  // Monitor: pops the scoreboard on each new result and drives out_ready.
  initial begin
    logic [W-1:0] held_inv;
    logic         held_err;
    int           hold_cnt;
    out_ready = 1'b0;
    held_inv  = '0;
    held_err  = 1'b0;
    hold_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        holding   = 0;
        out_ready = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!holding) begin
          holding  = 1;
          hold_cnt = 0;
          held_inv = inv;
          held_err = err;
          check_result();
        end else begin
          hold_cnt++;
          check(inv == held_inv && err == held_err, "hold_stable", inv, held_inv);
        end
        if (bp_mode) begin
          check(in_ready == 1'b0, "busy_in_ready", W'(in_ready), '0);
          out_ready = (hold_cnt >= 20);
        end else begin
          out_ready = ($urandom_range(3) != 0);
        end
        if (out_ready) begin
          holding = 0;
          hs_cyc  = cyc;
          bp_mode = 0;
        end
      end else begin
        out_ready = ($urandom_range(1) == 1);
      end
    end
  end

  initial begin
    logic [W-1:0] x_inv;
    int           acc;
    int           acc_b;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    x_inv    = '0;
    x_inv[130] = 1'b1;
    x_inv[12]  = 1'b1;
    x_inv[1:0] = 2'b11;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check(in_ready == 1'b1, "reset_in_ready", W'(in_ready), W'(1));
    check(out_valid == 1'b0, "reset_out_valid", W'(out_valid), '0);
    check(inv == '0, "reset_inv", inv, '0);
    check(err == 1'b0, "reset_err", W'(err), '0);
    rst_n = 1'b1;

    // T1 / T2 / T3
    send(W'(1), 1'b1, W'(1), 1'b0, 2, acc);
    drain();
    send(W'(2), 1'b1, x_inv, 1'b0, -1, acc);
    drain();
    send({{(W-M){1'b1}}, M'(0)}, 1'b1, '0, 1'b1, 0, acc);
    send_rand();
    drain();

    // T4: random operands with throttled out_ready
    for (int i = 0; i < N_RANDOM; i++) begin
      send_rand();
      repeat ($urandom_range(2)) @(negedge clk);
    end
    drain();

    // T5: back-pressure with a second operand waiting
    bp_mode = 1;
    send_rand();
    send(rand_op(), 1'b0, '0, 1'b0, -1, acc_b);
    check(acc_b == hs_cyc + 2, "accept_after_handshake", W'(acc_b), W'(hs_cyc + 2));
    drain();
    check(n_results == n_sent, "result_count", W'(n_results), W'(n_sent));

    // T6: reset mid-inversion
    send({{(W-M){1'b0}}, M'(1) << 130}, 1'b0, '0, 1'b0, -1, acc);
    repeat (10) @(negedge clk);
    check(in_ready == 1'b0, "busy_before_reset", W'(in_ready), '0);
    #2 rst_n = 1'b0;
    n_sent -= sb.size();
    sb.delete();
    #1;
    check(out_valid == 1'b0, "async_reset_out_valid", W'(out_valid), '0);
    check(in_ready == 1'b1, "async_reset_in_ready", W'(in_ready), W'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(W'(2), 1'b1, x_inv, 1'b0, -1, acc);
    drain();
    check(n_results == n_sent, "final_result_count", W'(n_results), W'(n_sent));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
